// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// occupancy count, runtime almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_param #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FWFT       = 0,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] data_read,
  input  logic [AW:0]           afull_thresh,
  input  logic [AW:0]           aempty_thresh,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic                  half_full,
  output logic                  half_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [AW:0] DepthC = (AW + 1)'(DEPTH);
  localparam logic [AW:0] HalfC  = (AW + 1)'(DEPTH / 2);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_acc, rd_acc;

  // Acceptance uses the pre-edge count, so a full FIFO never takes a write even
  // when a read retires a word in the same cycle (and vice versa when empty).
  assign wr_acc = write_enable && !full;
  assign rd_acc = read_enable && !empty;

  assign count        = count_q;
  assign full         = (count_q == DepthC);
  assign empty        = (count_q == '0);
  assign half_full    = (count_q >= HalfC);
  assign half_empty   = (count_q <= HalfC);
  assign almost_full  = (count_q >= afull_thresh);
  assign almost_empty = (count_q <= aempty_thresh);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
      if (write_enable && full) overflow_d = 1'b1;
      if (read_enable && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) begin
      mem_q[wr_ptr_q] <= data_write;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_read = mem_q[rd_ptr_q];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (flush) begin
        rdata_d = '0;
      end else if (rd_acc) begin
        rdata_d = mem_q[rd_ptr_q];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign data_read = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard and an FWFT instance share stimulus and are
// checked against a queue-based reference model after every clock edge.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       we;
  logic       re;
  logic [8:0] wd;
  logic [4:0] afull_th;
  logic [4:0] aempty_th;

  logic [8:0] dr0, dr1;
  logic [4:0] cnt0, cnt1;
  logic full0, empty0, hf0, he0, af0, ae0, ovf0, unf0;
  logic full1, empty1, hf1, he1, af1, ae1, ovf1, unf1;

  int passes = 0;
  int total  = 0;

  // Reference model
  logic [8:0] mq[$];
  bit         m_ovf;
  bit         m_unf;
  logic [8:0] m_dr0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(9), .DEPTH(16), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .write_enable(we), .data_write(wd),
    .read_enable(re), .data_read(dr0), .afull_thresh(afull_th), .aempty_thresh(aempty_th),
    .count(cnt0), .full(full0), .empty(empty0), .half_full(hf0), .half_empty(he0),
    .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.DATA_WIDTH(9), .DEPTH(16), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .write_enable(we), .data_write(wd),
    .read_enable(re), .data_read(dr1), .afull_thresh(afull_th), .aempty_thresh(aempty_th),
    .count(cnt1), .full(full1), .empty(empty1), .half_full(hf1), .half_empty(he1),
    .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(unf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string ph);
    int c;
    c = mq.size();
    chk({ph, ".count"},        32'(cnt0), 32'(c));
    chk({ph, ".full"},         32'(full0), 32'(c == 16));
    chk({ph, ".empty"},        32'(empty0), 32'(c == 0));
    chk({ph, ".half_full"},    32'(hf0), 32'(c >= 8));
    chk({ph, ".half_empty"},   32'(he0), 32'(c <= 8));
    chk({ph, ".almost_full"},  32'(af0), 32'(c >= int'(afull_th)));
    chk({ph, ".almost_empty"}, 32'(ae0), 32'(c <= int'(aempty_th)));
    chk({ph, ".overflow"},     32'(ovf0), 32'(m_ovf));
    chk({ph, ".underflow"},    32'(unf0), 32'(m_unf));
    chk({ph, ".data_read"},    32'(dr0), 32'(m_dr0));
    chk({ph, ".fwft_count"},   32'(cnt1), 32'(c));
    chk({ph, ".fwft_flags"},   32'({full1, empty1, ovf1, unf1}),
        32'({c == 16, c == 0, m_ovf, m_unf}));
    if (c > 0) chk({ph, ".fwft_data"}, 32'(dr1), 32'(mq[0]));
  endtask

  // Drives one cycle of requests, advances the model by the FIFO rules, then checks.
  task automatic step(input string ph, input logic w, input logic [8:0] d,
                      input logic r, input logic f);
    bit mfull, mempty;
    we = w; wd = d; re = r; flush = f;
    mfull  = (mq.size() == 16);
    mempty = (mq.size() == 0);
    if (f) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
      m_dr0 = '0;
    end else begin
      if (w && mfull) m_ovf = 1;
      if (r && mempty) m_unf = 1;
      if (r && !mempty) m_dr0 = mq.pop_front();
      if (w && !mfull) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    we = 0; re = 0; flush = 0;
    check_all(ph);
  endtask

  initial begin
    rst_n = 0; flush = 0; we = 0; re = 0; wd = '0;
    afull_th = 5'd14; aempty_th = 5'd2;
    m_ovf = 0; m_unf = 0; m_dr0 = '0;
    #23 rst_n = 1;
    check_all("reset");
    step("idle", 0, '0, 0, 0);

    for (int i = 0; i < 16; i++) step("fill", 1, 9'(i), 0, 0);
    for (int i = 0; i < 16; i++) step("drain", 0, '0, 1, 0);

    // Full with simultaneous write and read: read wins, write dropped.
    for (int i = 0; i < 16; i++) step("fill2", 1, 9'($urandom_range(0, 511)), 0, 0);
    step("full_wr_rd", 1, 9'h0AA, 1, 0);
    step("ovf_hold", 0, '0, 0, 0);
    step("ovf_hold", 0, '0, 1, 0);
    while (mq.size() > 0) step("drain2", 0, '0, 1, 0);

    // Empty with simultaneous write and read: write wins, read dropped.
    step("flush1", 0, '0, 0, 1);
    step("empty_wr_rd", 1, 9'h1A5, 1, 0);
    step("fwft_show", 0, '0, 0, 0);
    chk("fwft_1a5", 32'(dr1), 32'h1A5);

    // Thresholds.
    step("flush2", 0, '0, 0, 1);
    afull_th = 5'd12; aempty_th = 5'd3;
    #1 check_all("thresh_set");
    for (int i = 0; i < 8; i++) step("thr_fill", 1, 9'($urandom_range(0, 511)), 0, 0);
    afull_th = 5'd5;
    #1;
    chk("afull_immediate", 32'(af0), 32'd1);
    check_all("thresh_chg");
    afull_th = 5'd12;
    for (int i = 0; i < 8; i++) step("thr_fill2", 1, 9'($urandom_range(0, 511)), 0, 0);

    // Pointer wrap with steady occupancy of 3.
    step("flush3", 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) step("wrap_pre", 1, 9'($urandom_range(0, 511)), 0, 0);
    for (int i = 0; i < 40; i++) step("wrap", 1, 9'($urandom_range(0, 511)), 1, 0);
    step("flush_wr", 1, 9'h155, 0, 1);
    step("after_flush", 0, '0, 0, 0);

    // Randomised traffic alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 400; i++) begin
      int pw;
      pw = ((i / 50) % 2 == 1) ? 80 : 25;
      if ($urandom_range(0, 19) == 0) begin
        afull_th  = 5'($urandom_range(0, 16));
        aempty_th = 5'($urandom_range(0, 16));
      end
      step("rand", ($urandom_range(0, 99) < pw), 9'($urandom_range(0, 511)),
           ($urandom_range(0, 99) < 100 - pw), ($urandom_range(0, 59) == 0));
    end

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 5; i++) step("pre_rst", 1, 9'($urandom_range(0, 511)), 0, 0);
    step("pre_rst_ovf", 0, '0, 1, 0);
    #3 rst_n = 0;
    #1;
    mq.delete(); m_ovf = 0; m_unf = 0; m_dr0 = '0;
    check_all("mid_reset");
    #2 rst_n = 1;
    @(posedge clk); #1;
    check_all("post_reset");
    for (int i = 0; i < 4; i++) step("post_rst_wr", 1, 9'($urandom_range(0, 511)), 0, 0);
    for (int i = 0; i < 5; i++) step("post_rst_rd", 0, '0, 1, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
